// File: rtl/p16_to_f32.sv
// Posit16 (es=1) to IEEE-754 binary32 converter, 3-stage valid/ready pipeline.
// Every posit16/es=1 value fits exactly in binary32, so the datapath has no rounding.
module p16_to_f32 #(
   parameter int unsigned N    = 16,
   parameter int unsigned ES   = 1,
   parameter int unsigned FN   = 32,
   parameter int unsigned FE   = 8,
   parameter int unsigned BIAS = 127,
   parameter int unsigned FS   = 23
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  posit_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [FN-1:0] float_out
);

   // Bits left after sign and the shortest regime (run + terminator): {e, frac}
   localparam int unsigned RW = N - 2 - ES;
   localparam int unsigned FW = RW - ES;

   logic adv;

   logic          s1_valid, s1_zero, s1_nar, s1_sign;
   logic [N-2:0]  s1_abs;
   logic [N-2:0]  p_abs;

   logic          s2_valid, s2_zero, s2_nar, s2_sign;
   logic [4:0]    s2_k;
   logic [RW-1:0] s2_rem;

   logic          reg_bit;
   logic [N-2:0]  run_bits;
   logic [3:0]    run_len;
   logic          run_end;
   logic [4:0]    k_val;
   logic [RW-1:0] rem_val;

   logic [FE-1:0] k_ext;
   logic [FE-1:0] exp_f;
   logic [FS-1:0] mant_f;

   // Every stage moves together; a bubble at the output never blocks the pipe
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Magnitude of the operand; only the low N-1 bits matter (NaR folds to zero here)
   assign p_abs = posit_in[N-1] ? (~posit_in[N-2:0] + 1'b1) : posit_in[N-2:0];

   // Stage 1: register operand classification and magnitude
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_sign  <= 1'b0;
         s1_abs   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_zero  <= (posit_in == '0);
         s1_nar   <= (posit_in == {1'b1, {(N-1){1'b0}}});
         s1_sign  <= posit_in[N-1];
         s1_abs   <= p_abs;
      end
   end

   // Regime run length: first bit that differs from the leading regime bit
   always_comb begin
      reg_bit  = s1_abs[N-2];
      run_bits = reg_bit ? ~s1_abs : s1_abs;
      run_len  = 4'd15;
      run_end  = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!run_end && run_bits[i]) begin
            run_len = 4'(N - 2 - i);
            run_end = 1'b1;
         end
      end
      k_val   = reg_bit ? ({1'b0, run_len} - 5'd1) : (5'd0 - {1'b0, run_len});
      // Drop the run and its terminator; a 16-bit shift of a full run clears the field
      rem_val = RW'((s1_abs << ({1'b0, run_len} + 5'd1)) >> 2);
   end

   // Stage 2: register decoded regime and left-aligned exponent/fraction bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_zero  <= 1'b0;
         s2_nar   <= 1'b0;
         s2_sign  <= 1'b0;
         s2_k     <= '0;
         s2_rem   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_zero  <= s1_zero;
         s2_nar   <= s1_nar;
         s2_sign  <= s1_sign;
         s2_k     <= k_val;
         s2_rem   <= rem_val;
      end
   end

   // Biased exponent 2k + e + BIAS and the zero-padded mantissa
   always_comb begin
      k_ext  = {{(FE-5){s2_k[4]}}, s2_k};
      exp_f  = (k_ext << 1) + {{(FE-1){1'b0}}, s2_rem[RW-1]} + FE'(BIAS);
      mant_f = {s2_rem[FW-1:0], {(FS-FW){1'b0}}};
   end

   // Stage 3: resolve specials (NaR over zero) and register the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         float_out <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_nar) begin
            float_out <= {1'b0, {FE{1'b1}}, 1'b1, {(FS-1){1'b0}}};
         end else if (s2_zero) begin
            float_out <= '0;
         end else begin
            float_out <= {s2_sign, exp_f, mant_f};
         end
      end
   end

endmodule

// File: tb/tb_p16_to_f32.sv
// Bench for p16_to_f32: directed cases, stall, reset, and a randomized-handshake full sweep.
module tb_p16_to_f32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] posit_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] float_out;

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   bit rand_ready = 1'b0;

   logic [31:0] exp_q[$];
   logic [15:0] in_q[$];

   p16_to_f32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .posit_in  (posit_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .float_out (float_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Value-level decode: walk the posit fields, form the real value, then repack as binary32
   function automatic logic [31:0] ref_f32(input logic [15:0] p);
      logic [15:0] a;
      logic        r;
      logic [63:0] db;
      logic [7:0]  ex;
      int          i, m, k, e;
      real         frac, w, v;
      if (p == 16'h0000) return 32'h0000_0000;
      if (p == 16'h8000) return 32'h7FC0_0000;
      a = p[15] ? 16'(-p) : p;
      r = a[14];
      m = 0;
      i = 14;
      while (i >= 0 && a[i] == r) begin
         m++;
         i--;
      end
      i--;
      k = r ? m - 1 : -m;
      e = 0;
      if (i >= 0) begin
         e = a[i] ? 1 : 0;
         i--;
      end
      frac = 0.0;
      w    = 0.5;
      while (i >= 0) begin
         if (a[i]) frac = frac + w;
         w = w / 2.0;
         i--;
      end
      v  = (1.0 + frac) * (2.0 ** (2 * k + e));
      db = $realtobits(v);
      ex = 8'(int'(db[62:52]) - 1023 + 127);
      return {p[15], ex, db[51:29]};
   endfunction

   // Binary32 to posit16/es=1 for exactly-representable values (round-trip check)
   function automatic logic [15:0] enc_p16(input logic [31:0] f);
      int          scale, k, e, n;
      logic [63:0] acc;
      logic [14:0] body;
      if (f[30:0] == 31'd0) return 16'h0000;
      if (f[30:23] == 8'hFF) return 16'h8000;
      scale = int'(f[30:23]) - 127;
      k     = scale >>> 1;
      e     = scale & 1;
      acc   = '0;
      n     = 0;
      if (k >= 0) begin
         for (int j = 0; j <= k; j++) begin
            acc = {acc[62:0], 1'b1};
            n++;
         end
         acc = {acc[62:0], 1'b0};
      end else begin
         for (int j = 0; j < -k; j++) begin
            acc = {acc[62:0], 1'b0};
            n++;
         end
         acc = {acc[62:0], 1'b1};
      end
      n++;
      acc = {acc[62:0], e[0]};
      n++;
      for (int j = 22; j >= 0; j--) begin
         acc = {acc[62:0], f[j]};
         n++;
      end
      body = 15'(acc >> (n - 15));
      return f[31] ? 16'(-{1'b0, body}) : {1'b0, body};
   endfunction

   // Scoreboard: handshakes observed mid-cycle take effect on the next rising edge
   initial begin
      logic [31:0] want;
      logic [15:0] pin;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  check("unexpected_out", {31'd0, out_valid}, 32'd0);
               end else begin
                  want = exp_q.pop_front();
                  pin  = in_q.pop_front();
                  check("model", float_out, want);
                  check("roundtrip", {16'd0, enc_p16(float_out)}, {16'd0, pin});
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(ref_f32(posit_in));
               in_q.push_back(posit_in);
            end
         end
      end
   end

   // Random downstream readiness when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 15) != 0);
      end
   end

   task automatic send(input logic [15:0] p);
      int g;
      g        = 0;
      posit_in = p;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && g < 200) begin
         g++;
         @(negedge clk);
      end
      if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      posit_in = 16'($urandom);
   endtask

   task automatic single(input string tag, input logic [15:0] p, input logic [31:0] want);
      int lat;
      posit_in = p;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      posit_in = 16'($urandom);
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, lat, 3);
      check(tag, float_out, want);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   logic [15:0] d_in  [9] = '{16'h4000, 16'h5000, 16'h4800, 16'hC000, 16'h7FFF,
                              16'h0001, 16'h8001, 16'h0000, 16'h8000};
   logic [31:0] d_out [9] = '{32'h3F80_0000, 32'h4000_0000, 32'h3FC0_0000, 32'hBF80_0000,
                              32'h4D80_0000, 32'h3180_0000, 32'hCD80_0000, 32'h0000_0000,
                              32'h7FC0_0000};

   initial begin
      int base;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      posit_in  = '0;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_float_out", float_out, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Directed single operands, latency and value
      for (int i = 0; i < 9; i++) begin
         single($sformatf("single_%04h", d_in[i]), d_in[i], d_out[i]);
      end

      // Back-to-back stream
      send(16'h4000);
      send(16'h5000);
      send(16'h4800);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_valid_%0d", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("b2b_data_%0d", i), float_out, d_out[i]);
         @(posedge clk);
         #1;
      end
      wait_drain("b2b_drain");

      // Back-pressure with a full pipeline
      out_ready = 1'b0;
      send(16'h7FFF);
      send(16'h0001);
      send(16'h8001);
      base     = n_out;
      in_valid = 1'b1;
      posit_in = 16'h4800;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_float_out", float_out, 32'h4D80_0000);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("bp_drain");
      check("bp_count", n_out - base, 3);

      // Reset with two operands in flight
      out_ready = 1'b0;
      send(16'h7FFF);
      send(16'h0001);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_float_out", float_out, 32'd0);
      exp_q.delete();
      in_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      single("post_rst", 16'h4800, 32'h3FC0_0000);

      // Full sweep with random idle cycles and random downstream readiness
      rand_ready = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            @(posedge clk);
            #1;
         end
         send(16'(i));
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      wait_drain("sweep_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/p16_to_f32.md
Name: p16_to_f32

Overview:
Pipelined converter from 16-bit posit (es=1) to IEEE-754 single-precision float. It is the decode direction paired with the f32-to-p16 encoder in the posit datapath. Every posit16/es=1 value is exactly representable in float32, so no rounding is required. It has a 3-stage valid/ready pipeline with full-throughput back-pressure.

Parameters:
N, 16, posit width (only 16 supported)
es, 1, posit exponent bits (only 1 supported)
FN, 32, float width
FE, 8, float exponent width
BIAS, 127, float exponent bias (2**(FE-1)-1)
FS, 23, float fraction width (FN-FE-1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  posit_in holds a valid operand
in_ready  output  1  block accepts an operand this cycle
posit_in  input  16  posit operand
out_valid  output  1  float_out holds a valid result
out_ready  input  1  downstream accepts the result this cycle
float_out  output  32  converted float

Behaviour:
- Reset (async assert, sync deassert by system): all stage valid bits clear; out_valid=0; float_out=0; in_ready=1 after reset.
- Pipeline advance: adv = ~out_valid | out_ready. All three stages load when adv=1 and hold when adv=0. in_ready = adv, combinational.
- Transfer rule: input is taken when in_valid & in_ready. Output is consumed when out_valid & out_ready. Stage valid bits shift with the data, and a bubble enters when in_valid=0.
- Latency: 3 cycles from input handshake to out_valid with no stall. Throughput is 1 per cycle. Stalls keep every stage bit-stable, with no loss or duplication.
- Stage 1 (register input):
  - zero = (p==0x0000), nar = (p==0x8000), sign = p[15].
  - abs = sign ? -p : p (16-bit two's complement). Bits abs[14:0] are used.
- Stage 2 (regime decode):
  - r = abs[14]. m = length of the run of bits equal to r, starting at bit 14 (1..15).
  - k = r ? m-1 : -m (signed, range -14..14).
  - Remaining bits after the run and its terminator (terminator absent when m=15) are left-aligned into a 13-bit field {e, frac[11:0]}. Missing bits are 0.
- Stage 3 (assemble):
  - scale = 2k + e (range -28..28). Exponent field = scale + BIAS (99..155, never 0 or 255).
  - Mantissa field = {frac[11:0], 11'b0}.
  - float_out = {sign, exp, mant}.
- Special cases, resolved in stage 3 with priority nar > zero > normal:
  - 0x8000 (NaR) -> 0x7FC00000 (quiet NaN).
  - 0x0000 -> 0x00000000.
- Negative zero is never produced.
- Result exactness: round-tripping float_out through the f32-to-p16 encoder returns posit_in for every input except NaR. NaN maps back to NaR.
- Reset mid-operation: all in-flight results are discarded and out_valid drops immediately.
- in_valid may toggle freely; posit_in is ignored when in_valid=0.
- out_ready low with out_valid=0 does not stall the pipeline (bubbles collapse).

Test Plan:
- Single operands with no stall: 0x4000->0x3F800000, 0x5000->0x40000000, 0x4800->0x3FC00000, 0xC000->0xBF800000. out_valid rises exactly 3 cycles after the handshake.
- Extremes and specials: 0x7FFF->0x4D800000, 0x0001->0x31800000, 0x8001->0xCD800000, 0x0000->0x00000000, 0x8000->0x7FC00000.
- Back-to-back stream of 0x4000, 0x5000, 0x4800 with out_ready=1 -> three consecutive out_valid cycles in order.
- Back-pressure: hold out_ready=0 for 5 cycles with a full pipeline. Required: in_ready=0, float_out stable, no lost or duplicate results after release.
- Assert rst_n low with 2 operands in flight. Required: out_valid=0 and float_out=0 immediately. The first result after release comes from the first post-reset input.
- Exhaustive sweep of all 65536 posits with random out_ready. Required: output matches a reference model, and re-encoding through f32_to_p16 reproduces the input (NaR excepted).
